// File: rtl/queue_pkg.sv
// queue_pkg: shared FSM state type and circular pointer increment for queue_param.
package queue_pkg;

   typedef enum logic {WAIT, RUN} state_t;

   function automatic int ptr_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/queue_ram.sv
// queue_ram: DEPTH x WIDTH register array, one write port, registered read port, no reset.
module queue_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Read returns the pre-write word when both ports hit the same entry (full queue, enq+deq).
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/queue_param.sv
// queue_param: parametrised circular-buffer FIFO with sticky overflow/underflow error and flush.
// Define QUEUE_ALMOST_FLAGS_EN to add registered almost_full_out/almost_empty_out.
module queue_param
   import queue_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
`ifdef QUEUE_ALMOST_FLAGS_EN
   ,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1
`endif
) (
   input  logic                       clock_10KHZ,
   input  logic                       reset,
   input  logic                       verifica,
   input  logic                       flush_in,
   input  logic                       enqueue_in,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       dequeue_in,
   input  logic                       clear_err_in,
   output logic [WIDTH-1:0]           data_out,
   output logic                       data_valid_out,
   output logic [$clog2(DEPTH+1)-1:0] len_out,
   output logic                       full_out,
   output logic                       empty_out,
   output logic                       err_out
`ifdef QUEUE_ALMOST_FLAGS_EN
   ,
   output logic                       almost_full_out,
   output logic                       almost_empty_out
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   state_t          state, state_nx;
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [LW-1:0]   len_nx;
   logic            run, do_enq, do_deq, fault, loaded;
   logic [WIDTH-1:0] rd_data;

   assign full_out  = len_out == LW'(DEPTH);
   assign empty_out = len_out == '0;
   // The RAM read register has no reset; mask it until the first real dequeue.
   assign data_out  = loaded ? rd_data : '0;

   always_ff @(posedge clock_10KHZ or negedge reset) begin
      if (!reset) state <= WAIT;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = verifica ? RUN : WAIT;
      run      = state == RUN;
      do_enq   = run & !flush_in & enqueue_in & (!full_out | dequeue_in);
      do_deq   = run & !flush_in & dequeue_in & !empty_out;
      fault    = run & !flush_in & ((enqueue_in & full_out & !dequeue_in) | (dequeue_in & empty_out));
      len_nx   = flush_in ? '0 : len_out + LW'(do_enq) - LW'(do_deq);
   end

   always_ff @(posedge clock_10KHZ or negedge reset) begin
      if (!reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         len_out        <= '0;
         data_valid_out <= 1'b0;
         err_out        <= 1'b0;
         loaded         <= 1'b0;
      end else begin
         wr_ptr         <= flush_in ? '0 : do_enq ? PW'(ptr_inc(int'(wr_ptr), DEPTH)) : wr_ptr;
         rd_ptr         <= flush_in ? '0 : do_deq ? PW'(ptr_inc(int'(rd_ptr), DEPTH)) : rd_ptr;
         len_out        <= len_nx;
         data_valid_out <= do_deq;
         err_out        <= fault | (err_out & !(run & clear_err_in));
         loaded         <= loaded | do_deq;
      end
   end

`ifdef QUEUE_ALMOST_FLAGS_EN
   always_ff @(posedge clock_10KHZ or negedge reset) begin
      if (!reset) begin
         almost_full_out  <= 1'b0;
         almost_empty_out <= 1'b1;
      end else begin
         almost_full_out  <= len_nx >= LW'(AF_LEVEL);
         almost_empty_out <= len_nx <= LW'(AE_LEVEL);
      end
   end
`endif

   queue_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk     (clock_10KHZ),
      .wr_en   (do_enq),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_en   (do_deq),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

endmodule

// File: doc/queue_param.md
Name: queue_param

Overview:
- Parametrised circular-buffer FIFO; successor to the fixed 8x8 shift-register queue.
- Generic data width and depth; single-cycle enqueue/dequeue strobes; simultaneous enqueue+dequeue; full/empty flags; sticky overflow/underflow error; synchronous flush.
- Sits between a producer (e.g. a keypad/serial capture block) and a consumer (e.g. a display or transmit block) in the 10 kHz domain, gated by a start enable from module_top.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2, any value; power of two not required).
- AF_LEVEL, DEPTH-1, almost-full threshold (used only with the optional feature).
- AE_LEVEL, 1, almost-empty threshold (used only with the optional feature).

Ports:
- clock_10KHZ  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- verifica  in  1  level enable from module_top; operations are accepted only while the FSM is in RUN.
- flush_in  in  1  synchronous clear of contents; the error flag is not cleared.
- enqueue_in  in  1  one-cycle write strobe.
- data_in  in  WIDTH  write data, sampled with enqueue_in.
- dequeue_in  in  1  one-cycle read strobe.
- clear_err_in  in  1  clears err_out.
- data_out  out  WIDTH  registered read data.
- data_valid_out  out  1  pulses high for one cycle when data_out is updated.
- len_out  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full_out  out  1  high when len_out == DEPTH.
- empty_out  out  1  high when len_out == 0.
- err_out  out  1  sticky; set on overflow or underflow.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM = WAIT.
  - Pointers = 0.
  - len_out = 0, data_out = 0, data_valid_out = 0, err_out = 0.
  - empty_out = 1, full_out = 0.
  - Storage array is not reset.
- FSM states: WAIT, RUN.
  - WAIT -> RUN when verifica = 1.
  - RUN -> WAIT when verifica = 0; contents are kept.
  - In WAIT, enqueue_in and dequeue_in are ignored and err_out does not change.
- Storage: DEPTH x WIDTH array with write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits. A pointer wraps to 0 when incremented from DEPTH-1.
- Enqueue (RUN, enqueue_in = 1, not full): mem[wr_ptr] <= data_in; wr_ptr advances; len_out + 1.
- Dequeue (RUN, dequeue_in = 1, not empty): data_out <= mem[rd_ptr]; rd_ptr advances; len_out - 1; data_valid_out = 1 on the next cycle. Latency is one clock from strobe to data.
- Simultaneous enqueue and dequeue:
  - Not empty: both are performed and len_out is unchanged. This applies when full as well.
  - Empty: only the enqueue is performed; no bypass; underflow is flagged.
- Overflow: enqueue while full and no dequeue in the same cycle -> write dropped, err_out <= 1.
- Underflow: dequeue while empty -> data_out holds its value, data_valid_out stays 0, err_out <= 1.
- flush_in (any state):
  - Pointers = 0, len_out = 0.
  - data_out holds its value; data_valid_out = 0.
  - Takes priority over enqueue and dequeue in the same cycle.
- clear_err_in clears err_out. If an error condition occurs in the same cycle, set wins.
- full_out and empty_out are decoded combinationally from registered len_out.
- data_valid_out is 0 in every cycle with no successful dequeue.

Optional Feature:
- Macro: QUEUE_ALMOST_FLAGS_EN.
- Defined: adds output ports almost_full_out (len_out >= AF_LEVEL) and almost_empty_out (len_out <= AE_LEVEL). Both are registered, updated on the same edge as len_out, and reset to almost_full_out = 0, almost_empty_out = 1.
- Undefined: these ports and their logic do not exist; AF_LEVEL and AE_LEVEL are unused.

Decomposition:
- Package queue_pkg:
  - state_t enum {WAIT, RUN}.
  - Function ptr_inc(ptr, depth) that implements the wrap.
- Sub-module queue_ram: plain DEPTH x WIDTH register array with one write port and a registered read port, no reset. It is instantiated once.
- Pointer, count and flag logic stay in queue_param.

Test Plan:
- Reset then verifica = 1; enqueue 0xA1, 0xB2, 0xC3; dequeue x3 -> data_out is A1, B2, C3 one cycle after each strobe; data_valid_out pulses x3; len_out 3 -> 0; empty_out = 1.
- DEPTH = 8: enqueue 8 words -> full_out = 1, len_out = 8. A 9th enqueue -> dropped, err_out = 1. Then clear_err_in -> err_out = 0.
- Full queue, simultaneous enqueue 0x55 and dequeue -> head word is output, len_out stays 8, no error. After 8 more dequeues the last word is 0x55.
- Empty queue, dequeue -> err_out = 1, data_valid_out = 0, data_out unchanged. Simultaneous enqueue 0x77 + dequeue on empty -> len_out = 1, err_out = 1.
- DEPTH = 5 wrap-around: 20 interleaved enqueue/dequeue pairs with incrementing data -> output order is preserved, len_out never exceeds 5.
- Load 3 words, verifica = 0, strobe enqueue/dequeue -> ignored. Then pulse reset low mid-stream -> len_out = 0, empty_out = 1, FSM = WAIT. Separately, flush_in with 3 words loaded -> len_out = 0, err_out unchanged.
